usb_sie_tx: RTL and testbench

- Low-speed USB transmit packetizer between the SIE control logic and the bit-level USB sender.
- The SIE preloads up to MAX_LEN payload bytes, then issues start with a PID.
- The block drives the sender's data/valid/ready byte handshake: PID byte, payload, CRC16 (data PIDs only), then drops valid to trigger EOP.
- Supports DATA0/DATA1 and handshake packets (ACK/NAK/STALL) for a low-speed device.

---
 rtl/usb_sie_tx.sv | 219 +++++++++++++++++++++
 tb/tb_usb_sie_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_tx.sv
// Low-speed USB transmit packetizer.
// Buffers up to MAX_LEN payload bytes and sends them to the bit-level sender on start.
// Byte order on the wire: PID byte, payload, CRC16 (data PIDs only). The block then
// drops tx_valid_o to request EOP and holds busy_o for EOP_CYCLES cycles of gap.
// Optional feature macro: USB_SIE_TX_CRC_INJECT_EN adds crc_inject_i. When the sampled
// value is set, the CRC high byte is sent with bit 0 inverted.
module usb_sie_tx #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned EOP_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic [3:0] buf_count_o,
  input  logic [3:0] pid_i,
  input  logic       start_i,
`ifdef USB_SIE_TX_CRC_INJECT_EN
  input  logic       crc_inject_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GapW = $clog2(EOP_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendPid,
    StSendData,
    StSendCrcLo,
    StSendCrcHi,
    StDrain,
    StGap
  } state_e;

  // USB CRC16: polynomial 0x8005 processed reflected (0xA001), LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [7:0]        buf_q [MAX_LEN];
  logic [3:0]        count_q, count_d;
  logic [3:0]        idx_q, idx_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              hs_q, hs_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_accept;
  logic              crc_inj;

`ifdef USB_SIE_TX_CRC_INJECT_EN
  logic inject_q;

  // Capture the CRC-corruption request together with the PID.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inject_q <= 1'b0;
    end else if (state_q == StIdle && start_i) begin
      inject_q <= crc_inject_i;
    end
  end

  assign crc_inj = inject_q;
`else
  assign crc_inj = 1'b0;
`endif

  // Payload storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      buf_q[count_q[IdxW-1:0]] <= wr_data_i;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      count_q   <= 4'd0;
      idx_q     <= 4'd0;
      crc_q     <= 16'hFFFF;
      tx_data_q <= 8'h00;
      gap_q     <= '0;
      hs_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      tx_data_q <= tx_data_d;
      gap_q     <= gap_d;
      hs_q      <= hs_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: buffer writes, packet sequencing and the post-EOP gap.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    tx_data_d = tx_data_q;
    gap_d     = gap_q;
    hs_d      = hs_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_accept = 1'b0;

    if (wr_en_i) begin
      if (state_q == StIdle && count_q < 4'(MAX_LEN)) begin
        wr_accept = 1'b1;
        count_d   = count_q + 4'd1;
        crc_d     = crc16_byte(crc_q, wr_data_i);
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // pid[1] set covers both data (11) and handshake (10) classes.
          if (pid_i[1]) begin
            state_d   = StSendPid;
            tx_data_d = {~pid_i, pid_i};
            hs_d      = ~pid_i[0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSendPid: begin
        if (tx_ready_i) begin
          if (hs_q) begin
            state_d   = StDrain;
            tx_data_d = 8'h00;
          end else if (count_q != 4'd0) begin
            state_d   = StSendData;
            tx_data_d = buf_q[0];
            idx_d     = 4'd1;
          end else begin
            state_d   = StSendCrcLo;
            tx_data_d = ~crc_q[7:0];
          end
        end
      end
      StSendData: begin
        // idx_q is the next byte to present; equal to count_q means the last one just went.
        if (tx_ready_i) begin
          if (idx_q == count_q) begin
            state_d   = StSendCrcLo;
            tx_data_d = ~crc_q[7:0];
          end else begin
            tx_data_d = buf_q[idx_q[IdxW-1:0]];
            idx_d     = idx_q + 4'd1;
          end
        end
      end
      StSendCrcLo: begin
        if (tx_ready_i) begin
          state_d   = StSendCrcHi;
          tx_data_d = ~crc_q[15:8] ^ {7'b0, crc_inj};
        end
      end
      StSendCrcHi: begin
        if (tx_ready_i) begin
          state_d   = StDrain;
          tx_data_d = 8'h00;
        end
      end
      StDrain: begin
        // This ready means the final byte has left the shifter; EOP follows.
        if (tx_ready_i) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapW'(EOP_CYCLES - 1)) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          count_d   = 4'd0;
          idx_d     = 4'd0;
          crc_d     = 16'hFFFF;
          tx_data_d = 8'h00;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign tx_valid_o  = (state_q != StIdle) && (state_q != StGap);
  assign tx_data_o   = tx_data_q;
  assign buf_count_o = count_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_usb_sie_tx.sv
// Testbench for usb_sie_tx: queue-based packet model checked every cycle, plus
// hand-computed byte sequences for the directed packets.
module tb_usb_sie_tx;

  localparam int EOP = 64;
  localparam int MAXL = 8;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [3:0] buf_count;
  logic [3:0] pid;
  logic       start;
  logic       crc_inject;
  logic       busy, done, err;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  usb_sie_tx #(
    .MAX_LEN   (MAXL),
    .EOP_CYCLES(EOP)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .buf_count_o (buf_count),
    .pid_i       (pid),
    .start_i     (start),
`ifdef USB_SIE_TX_CRC_INJECT_EN
    .crc_inject_i(crc_inject),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {MIdle, MActive, MGap} mphase_e;
  mphase_e    m_phase = MIdle;
  logic [7:0] m_buf [$];
  logic [7:0] m_wire [$];
  int         m_gap = 0;
  logic       m_err = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] log_q [$];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic model_step();
    logic [15:0] c;
    logic        inj;
    if (reset) begin
      m_phase = MIdle;
      m_buf.delete();
      m_wire.delete();
      m_err = 1'b0;
      m_done = 1'b0;
      m_gap = 0;
      return;
    end
    m_err = 1'b0;
    m_done = 1'b0;
    if (tx_ready && m_phase == MActive) log_q.push_back(tx_data);
    case (m_phase)
      MIdle: begin
        if (start) begin
          if (pid[1:0] == 2'b11) begin
            inj = 1'b0;
`ifdef USB_SIE_TX_CRC_INJECT_EN
            inj = crc_inject;
`endif
            c = 16'hFFFF;
            m_wire.delete();
            m_wire.push_back({~pid, pid});
            foreach (m_buf[i]) begin
              m_wire.push_back(m_buf[i]);
              c = crc_upd(c, m_buf[i]);
            end
            m_wire.push_back(~c[7:0]);
            m_wire.push_back(~c[15:8] ^ {7'b0, inj});
            m_phase = MActive;
          end else if (pid[1:0] == 2'b10) begin
            m_wire.delete();
            m_wire.push_back({~pid, pid});
            m_phase = MActive;
          end else begin
            m_err = 1'b1;
          end
        end
        if (wr_en) begin
          if (m_buf.size() < MAXL) m_buf.push_back(wr_data);
          else m_err = 1'b1;
        end
      end
      MActive: begin
        if (wr_en) m_err = 1'b1;
        if (tx_ready) begin
          if (m_wire.size() > 0) void'(m_wire.pop_front());
          else begin
            m_phase = MGap;
            m_gap = EOP;
          end
        end
      end
      default: begin
        if (wr_en) m_err = 1'b1;
        if (m_gap == 1) begin
          m_phase = MIdle;
          m_done = 1'b1;
          m_buf.delete();
        end else begin
          m_gap--;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase != MIdle));
      check("tx_valid", 32'(tx_valid), 32'(m_phase == MActive));
      check("buf_count", 32'(buf_count), 32'(m_buf.size()));
      check("err", 32'(err), 32'(m_err));
      check("done", 32'(done), 32'(m_done));
      if (m_phase == MActive)
        check("tx_data", 32'(tx_data), 32'((m_wire.size() > 0) ? m_wire[0] : 8'h00));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] exp_b [8];

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send_start(input logic [3:0] p, input logic inj);
    pid = p;
    crc_inject = inj;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    crc_inject = 1'b0;
  endtask

  task automatic ready_pulse();
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic run_sender(output int nrdy);
    nrdy = 0;
    while (tx_valid && nrdy < 20) begin
      ready_pulse();
      nrdy++;
    end
  endtask

  // Count busy cycles after tx_valid fell; a stray ready is thrown in mid-gap.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tx_ready = (n == 10);
      n++;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check({name, "_gap_len"}, 32'(n), 32'(EOP));
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string name, input int n);
    check({name, "_nbytes"}, 32'(log_q.size()), 32'(n + 1));
    for (int i = 0; i < n && i < log_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(log_q[i]), 32'(exp_b[i]));
  endtask

  int nr;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; pid = 4'h0; start = 1'b0;
    crc_inject = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // Ready while idle must be ignored.
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("idle_ready_valid", 32'(tx_valid), 32'd0);

    // ACK, empty buffer
    log_q.delete();
    send_start(4'h2, 1'b0);
    check("ack_pidbyte", 32'(tx_data), 32'hD2);
    run_sender(nr);
    check("ack_readies", 32'(nr), 32'd2);
    exp_b = '{8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("ack", 1);
    wait_done("ack");

    // DATA0 zero length
    log_q.delete();
    send_start(4'h3, 1'b0);
    run_sender(nr);
    check("d0_readies", 32'(nr), 32'd4);
    exp_b = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("d0", 3);
    wait_done("d0");

    // DATA1 with payload 00 01 02 03; CRC16 residue 8510 -> sent EF 7A
    for (int i = 0; i < 4; i++) write_byte(8'(i));
    check("d1_count", 32'(buf_count), 32'd4);
    log_q.delete();
    send_start(4'hB, 1'b0);
    run_sender(nr);
    check("d1_readies", 32'(nr), 32'd8);
    exp_b = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03, 8'hEF, 8'h7A, 8'h00};
    check_log("d1", 7);
    wait_done("d1");
    check("d1_count_after", 32'(buf_count), 32'd0);

    // Overfill: ninth byte dropped
    for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i));
    check("full_err", 32'(err), 32'd1);
    check("full_count", 32'(buf_count), 32'd8);
    // Illegal PID
    send_start(4'h1, 1'b0);
    check("badpid_err", 32'(err), 32'd1);
    check("badpid_busy", 32'(busy), 32'd0);
    check("badpid_count", 32'(buf_count), 32'd8);
    // Full-length DATA0, with write and start attempts while busy
    log_q.delete();
    send_start(4'h3, 1'b0);
    write_byte(8'h55);
    check("busy_wr_err", 32'(err), 32'd1);
    send_start(4'h2, 1'b0);
    check("busy_start_noerr", 32'(err), 32'd0);
    run_sender(nr);
    check("d8_readies", 32'(nr), 32'd12);
    wait_done("d8");

    // Handshake (NAK) with leftover payload: payload ignored, cleared at done
    write_byte(8'h77);
    write_byte(8'h88);
    log_q.delete();
    send_start(4'hA, 1'b0);
    run_sender(nr);
    check("nak_readies", 32'(nr), 32'd2);
    exp_b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("nak", 1);
    wait_done("nak");
    check("nak_count_after", 32'(buf_count), 32'd0);

    // Reset after the second ready of a DATA packet
    write_byte(8'hAA);
    write_byte(8'hBB);
    send_start(4'h3, 1'b0);
    ready_pulse();
    ready_pulse();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(buf_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    log_q.delete();
    send_start(4'h2, 1'b0);
    run_sender(nr);
    check("post_rst_readies", 32'(nr), 32'd2);
    exp_b = '{8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("post_rst", 1);
    wait_done("post_rst");

`ifdef USB_SIE_TX_CRC_INJECT_EN
    log_q.delete();
    send_start(4'h3, 1'b1);
    run_sender(nr);
    exp_b = '{8'hC3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("inject", 3);
    wait_done("inject");
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
